i2s_receiver: RTL
=================

Name: i2s_receiver

Overview:
- Inverse of the Audiosystem I2S output: deserializes an external I2S stream (audio_bclk, audio_lrclk, audio_din) into stereo frames.
- Pushes frames into a small FIFO drained through a valid/ready stream interface.
- Used for loopback verification of the Audiosystem transmitter and as the capture path for a future line-in.
- The I2S signals are asynchronous to clk and are synchronized internally; clk must be at least 4x audio_bclk.

Parameters:
- SAMPLE_WIDTH, 16: bits captured per channel slot.
- FIFO_DEPTH, 4: stereo frames buffered; power of two, at least 2.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous reset, active-high.
- audio_bclk  in  1: I2S bit clock, asynchronous.
- audio_lrclk  in  1: I2S word select; 0 = left, 1 = right; asynchronous.
- audio_din  in  1: I2S serial data, MSB first, asynchronous.
- sample_data  out  2*SAMPLE_WIDTH: head-of-FIFO frame, {left, right}.
- sample_valid  out  1: FIFO not empty.
- sample_ready  in  1: consumer accepts the head frame when sample_valid & sample_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1: current frame count.
- overrun  out  1: sticky; a frame was dropped because the FIFO was full.
- overrun_clear  in  1: clears overrun.

Behaviour:
- Reset values: sample_data=0, sample_valid=0, fifo_level=0, overrun=0, state=SEEK. All synchronizer stages and holding registers are cleared.
- Reset mid-frame discards the partial slot and any held left word. It does not spuriously detect a bclk edge on release.
- Synchronization:
  - audio_bclk, audio_lrclk and audio_din each pass through 2 flops.
  - A third bclk flop provides rise detection.
  - A rise event (rise) is a one-cycle pulse when the synced bclk is 1 and the delayed bclk is 0.
  - All capture logic acts only on rise cycles, using synced lrclk and din.
- Standard I2S timing: the first rise after a word-select change still carries the LSB of the previous slot. The MSB of the new slot arrives on the following rise.
- On each rise:
  - If bitcnt < SAMPLE_WIDTH, the shift register captures din at bit position SAMPLE_WIDTH-1-bitcnt.
  - bitcnt saturates at SAMPLE_WIDTH.
  - Bits beyond SAMPLE_WIDTH in a slot are ignored.
  - Unfilled LSBs of a short slot are 0.
- Slot end is a rise where lrclk differs from lrclk_prev (lrclk_prev is registered on every rise). The din on that rise is captured first, then the slot word is committed. bitcnt and the shift register are reset for the new slot, with the MSB captured on the next rise.
- States:
  - SEEK: ignore data. On the first lrclk change → LEFT if the new lrclk is 0, otherwise stay in SEEK.
  - LEFT: on slot end, latch left_hold → RIGHT.
  - RIGHT: on slot end, push {left_hold, word} to the FIFO → LEFT.
- A new frame is never formed from a right word alone.
- Push timing: the FIFO write happens in the rise cycle. sample_valid rises on the next clk, i.e. 3 clk edges after the first sync flop captures the committing bclk high.
- FIFO:
  - Push when full: the frame is dropped, FIFO contents are unchanged, and overrun is set on the next clk.
  - Simultaneous pop and push when full: both occur, no drop.
  - Simultaneous pop and push when empty: impossible, since sample_valid is 0.
  - fifo_level updates on the same edge as push/pop.
  - sample_data is stable while sample_valid=1 and no pop occurs.
- overrun_clear has priority over a simultaneous set only if no drop occurs in that same cycle. A drop in the same cycle keeps overrun=1.
- Glitch-free lrclk is required. An lrclk change inside SEEK with fewer than 1 captured bit is legal.

Test Plan:
- bclk = clk/8, 16-bit slots, left=0x1234, right=0xABCD, sample_ready=1 → one frame, sample_data=0x1234ABCD, fifo_level returns to 0, overrun=0.
- Reset released during a right slot, then frames (0x1111,0x2222) and (0x3333,0x4444) → first output 0x11112222; nothing emitted for the partial slot.
- sample_ready=0, 5 frames (n, n+1)·0x0101 for n=1..5 → fifo_level=4, overrun=1. Draining yields the first 4 frames in order; the 5th is lost. overrun_clear → overrun=0.
- 24-bit slots: left=0xA5A5 followed by 8 bits 0xFF, right=0x5A5A followed by 8 bits 0x00 → 0xA5A55A5A. 8-bit slots left=0xFF, right=0x81 → 0xFF008100.
- FIFO full with sample_ready=1 held exactly in the push cycle → no drop, overrun stays 0, order preserved.
- rst asserted for 1 clk mid-left-slot → all outputs 0 immediately. The next output is the first complete frame whose left slot starts after the release.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes an external I2S stream into the clk domain,
// assembles left/right slot words into stereo frames and buffers them in a
// small FIFO that is drained through a valid/ready stream interface.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          audio_bclk,
  input  logic                          audio_lrclk,
  input  logic                          audio_din,
  output logic [2*SAMPLE_WIDTH-1:0]     sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          overrun_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Synchronizer and edge-detect state
  logic [2:0]              bclk_sync;   // [0]/[1] synchronizer, [2] delayed copy
  logic [1:0]              lrclk_sync;
  logic [1:0]              din_sync;
  logic [1:0]              warm_cnt;    // edges seen since reset release
  logic                    rise;
  logic                    lrclk_s;
  logic                    din_s;

  // Slot assembly state
  logic                    lrclk_prev;
  logic [CW-1:0]           bitcnt;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [SAMPLE_WIDTH-1:0] word_next;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    slot_end;

  // Frame FSM
  state_t                  state;
  state_t                  next_state;
  logic                    latch_left;
  logic                    push_req;

  // FIFO
  logic [2*SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      full;
  logic                      pop;
  logic                      do_push;
  logic                      drop;

  // Two-flop synchronizers plus a third bclk flop for rise detection; the warm-up
  // counter keeps the reset-cleared delay flop from faking a rise on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours, exactly like hardware.
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      din_sync   <= '0;
      warm_cnt   <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[1:0], audio_bclk};
      lrclk_sync <= {lrclk_sync[0], audio_lrclk};
      din_sync   <= {din_sync[0], audio_din};
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign rise    = bclk_sync[1] & ~bclk_sync[2] & (warm_cnt == 2'd3);
  assign lrclk_s = lrclk_sync[1];
  assign din_s   = din_sync[1];

  // Slot word including the bit arriving on this rise; bits past SAMPLE_WIDTH drop out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    word_next = shreg;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (bitcnt == CW'(SAMPLE_WIDTH - 1 - i)) word_next[i] = din_s;
    end
    slot_end = (lrclk_s != lrclk_prev);
  end

  // Shift register, bit counter and word-select history, advanced on each rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrclk_prev <= 1'b0;
      bitcnt     <= '0;
      shreg      <= '0;
      left_hold  <= '0;
    end else if (rise) begin
      lrclk_prev <= lrclk_s;
      if (slot_end) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        shreg <= word_next;
        if (bitcnt != CW'(SAMPLE_WIDTH)) bitcnt <= bitcnt + CW'(1);
      end
      if (latch_left) left_hold <= word_next;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= next_state;
  end

  // Frame FSM next state: SEEK waits for a fresh left slot, then LEFT/RIGHT alternate.
  always_comb begin
    next_state = state;
    latch_left = 1'b0;
    push_req   = 1'b0;
    if (rise && slot_end) begin
      case (state)
        SEEK:    if (!lrclk_s) next_state = LEFT;
        LEFT: begin
          latch_left = 1'b1;
          next_state = RIGHT;
        end
        RIGHT: begin
          push_req   = 1'b1;
          next_state = LEFT;
        end
        default: next_state = SEEK;
      endcase
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = sample_valid & sample_ready;
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are never visible
    // while empty because sample_data is forced to zero then.
    if (do_push) mem[wr_ptr] <= {left_hold, word_next};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (overrun_clear) overrun <= 1'b0;
  end

  assign sample_valid = (count != '0);
  assign sample_data  = sample_valid ? mem[rd_ptr] : '0;
  assign fifo_level   = count;

endmodule
